// File: rtl/shift_deser.sv
// shift_deser: serial-in / parallel-out deserializer with start-bit framing,
// selectable bit order, a single-entry valid/ready holding register, and
// overrun / framing error detection.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  IDLE    | no word in progress; non-start bits are discarded
//  COLLECT | a word is partially received; bit_cnt counts bits so far
module shift_deser #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             s_vld,
  input  logic             s_start,
  input  logic             s_dir,
  output logic [WIDTH-1:0] q,
  output logic             q_vld,
  input  logic             q_rdy,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun,
  output logic             frame_err
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic             r_dir;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic             r_q_vld;
  logic             r_overrun;
  logic             r_frame_err;

  logic             w_start;
  logic             w_take;
  logic             w_dir;
  logic [WIDTH-1:0] w_sr_base;
  logic [WIDTH-1:0] w_sr_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_done;

  // Next shift-register / counter values; a start bit always begins from an
  // empty register so a discarded partial word cannot leak into the new one.
  always_comb begin
    w_start    = s_vld & s_start;
    w_take     = s_vld & (s_start | (r_state == ST_COLLECT));
    w_dir      = w_start ? s_dir : r_dir;
    w_sr_base  = w_start ? '0 : r_sr;
    w_sr_next  = w_dir ? {s_in, w_sr_base[WIDTH-1:1]}
                       : {w_sr_base[WIDTH-2:0], s_in};
    w_cnt_next = (w_start ? '0 : r_cnt) + CNT_W'(1);
    w_done     = w_take & (w_cnt_next == CNT_W'(WIDTH));
  end

  // Framing FSM, shift register, holding register and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sr        <= '0;
      r_dir       <= 1'b0;
      r_cnt       <= '0;
      r_q         <= '0;
      r_q_vld     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_start & (r_state == ST_COLLECT);

      if (w_take) begin
        r_dir <= w_dir;
        r_sr  <= w_sr_next;
        if (w_done) begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end else begin
          r_cnt   <= w_cnt_next;
          r_state <= ST_COLLECT;
        end
      end

      // A slot consumed on the completing edge is free for the new word.
      if (w_done) begin
        if (!r_q_vld || q_rdy) begin
          r_q     <= w_sr_next;
          r_q_vld <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_q_vld && q_rdy) begin
        r_q_vld <= 1'b0;
      end
    end
  end

  assign q         = r_q;
  assign q_vld     = r_q_vld;
  assign busy      = (r_state == ST_COLLECT);
  assign bit_cnt   = r_cnt;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule
